// File: rtl/bcd_ctrl_pkg.sv
// Shared definitions for the BCD stopwatch controller.
//   state_t      : FSM state encodings (also driven out on state_o)
//   BCD_MAX      : largest legal BCD digit value
//   presc_width(): prescaler register width for a given TICK_DIV (>= 1 bit)
package bcd_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10,
        ST_LAP   = 2'b11
    } state_t;

    localparam logic [3:0] BCD_MAX = 4'd9;

    function automatic int presc_width(input int tick_div);
        int w;
        w = $clog2(tick_div);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit of the stopwatch chain.
//   clk, rst_n : clock, async active-low reset
//   clr        : synchronous zero
//   inc        : advance by one this cycle (9 wraps to 0)
//   q          : digit value, always 0..9
//   at9        : q is 9, used by the controller to build the carry chain
module bcd_digit
    import bcd_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       inc,
    output logic [3:0] q,
    output logic       at9
);

    assign at9 = (q == BCD_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= 4'd0;
        end else if (clr) begin
            q <= 4'd0;
        end else if (inc) begin
            q <= at9 ? 4'd0 : q + 4'd1;
        end
    end

endmodule

// File: rtl/bcd_stopwatch_ctrl.sv
// Start/stop/lap/clear stopwatch controller driving a chain of BCD digits.
//   clk, rst_n             : clock, async active-low reset
//   start_stop, lap, clear : single-cycle button pulses
//   count_o                : displayed BCD value, digit 0 in [3:0]
//   running_o              : high in RUN or LAP
//   ovf_o                  : sticky wrap-past-all-9s flag, cleared by clear in PAUSE
//   state_o                : current FSM state
//
// state | meaning
// IDLE  | stopped, count is zero
// RUN   | counting, display live
// PAUSE | stopped, count held
// LAP   | counting, display frozen on the lap register
module bcd_stopwatch_ctrl
    import bcd_ctrl_pkg::*;
#(
    parameter int TICK_DIV = 10,
    parameter int DIGITS   = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start_stop,
    input  logic                lap,
    input  logic                clear,
    output logic [4*DIGITS-1:0] count_o,
    output logic                running_o,
    output logic                ovf_o,
    output logic [1:0]          state_o
);

    localparam int             PW         = presc_width(TICK_DIV);
    localparam logic [PW-1:0]  PRESC_LAST = PW'(TICK_DIV - 1);

    state_t              state_q, state_d;
    logic [PW-1:0]       presc_q;
    logic [4*DIGITS-1:0] live_cnt;
    logic [4*DIGITS-1:0] lap_q;
    logic [DIGITS-1:0]   at9;
    logic [DIGITS:0]     carry;
    logic                tick;
    logic                clr_evt;
    logic                lap_capture;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A higher-priority pulse that takes effect masks the lower ones.
    always_comb begin
        state_d     = state_q;
        clr_evt     = 1'b0;
        lap_capture = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_stop) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (start_stop) begin
                    state_d = ST_PAUSE;
                end else if (lap) begin
                    state_d     = ST_LAP;
                    lap_capture = 1'b1;
                end
            end
            ST_PAUSE: begin
                if (clear) begin
                    state_d = ST_IDLE;
                    clr_evt = 1'b1;
                end else if (start_stop) begin
                    state_d = ST_RUN;
                end
            end
            ST_LAP: begin
                if (start_stop) begin
                    state_d = ST_PAUSE;
                end else if (lap) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        running_o = (state_q == ST_RUN) || (state_q == ST_LAP);
        state_o   = state_q;
        count_o   = (state_q == ST_LAP) ? lap_q : live_cnt;
    end

    assign tick = running_o && (presc_q == PRESC_LAST);

    // Lap toggles never touch the prescaler, so the tick rate is unaffected.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
        end else if ((state_q == ST_IDLE) || clr_evt) begin
            presc_q <= '0;
        end else if (running_o) begin
            presc_q <= tick ? '0 : presc_q + PW'(1);
        end
    end

    // Captures the value on display this cycle, before any coincident tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lap_q <= '0;
        end else if (lap_capture) begin
            lap_q <= live_cnt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_o <= 1'b0;
        end else if (clr_evt) begin
            ovf_o <= 1'b0;
        end else if (carry[DIGITS]) begin
            ovf_o <= 1'b1;
        end
    end

    // carry[i] = tick and every digit below i is 9.
    assign carry[0] = tick;

    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        bcd_digit u_digit (
            .clk   (clk),
            .rst_n (rst_n),
            .clr   (clr_evt),
            .inc   (carry[i]),
            .q     (live_cnt[4*i +: 4]),
            .at9   (at9[i])
        );
        assign carry[i+1] = carry[i] & at9[i];
    end

endmodule

// File: tb/tb_bcd_stopwatch_ctrl.sv
// Self-checking bench. dut0 uses TICK_DIV=10; dut1 uses TICK_DIV=1 so the
// all-9s wrap is reachable in ~10k cycles. Stimulus pushes expected output
// tuples tagged with the cycle at which they must appear; a monitor on the
// falling edge pops and compares them.
module tb_bcd_stopwatch_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ss0, lp0, cl0, ss1, lp1, cl1;
    logic [15:0] cnt0, cnt1;
    logic        run0, run1, ovf0, ovf1;
    logic [1:0]  st0, st1;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        int          tgt;
        bit          which;
        logic [15:0] cnt;
        logic        run;
        logic        ovf;
        logic [1:0]  st;
        string       nm;
    } exp_t;

    exp_t sb[$];

    bcd_stopwatch_ctrl #(.TICK_DIV(10), .DIGITS(4)) dut0 (
        .clk(clk), .rst_n(rst_n), .start_stop(ss0), .lap(lp0), .clear(cl0),
        .count_o(cnt0), .running_o(run0), .ovf_o(ovf0), .state_o(st0)
    );

    bcd_stopwatch_ctrl #(.TICK_DIV(1), .DIGITS(4)) dut1 (
        .clk(clk), .rst_n(rst_n), .start_stop(ss1), .lap(lp1), .clear(cl1),
        .count_o(cnt1), .running_o(run1), .ovf_o(ovf1), .state_o(st1)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    // Monitor: compare every expectation whose cycle has arrived.
    initial forever begin
        @(negedge clk);
        while (sb.size() > 0 && sb[0].tgt <= cyc) begin
            exp_t e;
            logic [15:0] c;
            logic        r, o;
            logic [1:0]  s;
            e = sb.pop_front();
            c = e.which ? cnt1 : cnt0;
            r = e.which ? run1 : run0;
            o = e.which ? ovf1 : ovf0;
            s = e.which ? st1  : st0;
            checks = checks + 1;
            if (e.tgt < cyc) begin
                errors = errors + 1;
                $display("FAIL %s: expectation for cycle %0d missed (now %0d)", e.nm, e.tgt, cyc);
            end else if (c !== e.cnt || r !== e.run || o !== e.ovf || s !== e.st) begin
                errors = errors + 1;
                $display("FAIL %s @%0d: got count=%h run=%b ovf=%b state=%b, want count=%h run=%b ovf=%b state=%b",
                         e.nm, cyc, c, r, o, s, e.cnt, e.run, e.ovf, e.st);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached at cycle %0d, %0d expectations pending", cyc, sb.size());
        errors = errors + 1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    task automatic expect_at(input int tgt, input bit which, input logic [15:0] c,
                             input logic r, input logic o, input logic [1:0] s, input string nm);
        exp_t e;
        e.tgt = tgt; e.which = which; e.cnt = c; e.run = r; e.ovf = o; e.st = s; e.nm = nm;
        sb.push_back(e);
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    // Drive a one-cycle pulse starting at the current falling edge.
    task automatic pulse(input bit which, input logic s, input logic l, input logic c);
        if (which) begin ss1 = s; lp1 = l; cl1 = c; end
        else       begin ss0 = s; lp0 = l; cl0 = c; end
        @(negedge clk);
        ss0 = 1'b0; lp0 = 1'b0; cl0 = 1'b0;
        ss1 = 1'b0; lp1 = 1'b0; cl1 = 1'b0;
    endtask

    initial begin
        int b;
        rst_n = 1'b0;
        ss0 = 1'b0; lp0 = 1'b0; cl0 = 1'b0;
        ss1 = 1'b0; lp1 = 1'b0; cl1 = 1'b0;

        // Reset state, while reset is held.
        @(negedge clk);
        expect_at(cyc + 1, 0, 16'h0000, 1'b0, 1'b0, 2'b00, "reset0");
        expect_at(cyc + 1, 1, 16'h0000, 1'b0, 1'b0, 2'b00, "reset1");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        expect_at(cyc + 1, 0, 16'h0000, 1'b0, 1'b0, 2'b00, "idle0");
        wait_cyc(cyc + 2);

        // Start latency and steady rate: tick k is visible at N+10k+1.
        b = cyc;
        expect_at(b + 1,   0, 16'h0000, 1'b1, 1'b0, 2'b01, "start_run");
        expect_at(b + 10,  0, 16'h0000, 1'b1, 1'b0, 2'b01, "pre_first_tick");
        expect_at(b + 11,  0, 16'h0001, 1'b1, 1'b0, 2'b01, "first_tick");
        expect_at(b + 101, 0, 16'h0010, 1'b1, 1'b0, 2'b01, "tenth_tick");
        expect_at(b + 990, 0, 16'h0098, 1'b1, 1'b0, 2'b01, "count_98");
        expect_at(b + 991, 0, 16'h0099, 1'b1, 1'b0, 2'b01, "count_99");
        pulse(0, 1'b1, 1'b0, 1'b0);
        wait_cyc(b + 991);

        // Pause at 0099 and hold; prescaler is left at 1 by the pausing edge.
        expect_at(b + 992,  0, 16'h0099, 1'b0, 1'b0, 2'b10, "pause_99");
        expect_at(b + 1042, 0, 16'h0099, 1'b0, 1'b0, 2'b10, "hold_99");
        pulse(0, 1'b1, 1'b0, 1'b0);
        wait_cyc(b + 1045);
        b = cyc;
        expect_at(b + 1,  0, 16'h0099, 1'b1, 1'b0, 2'b01, "resume");
        expect_at(b + 9,  0, 16'h0099, 1'b1, 1'b0, 2'b01, "resume_pre");
        expect_at(b + 10, 0, 16'h0100, 1'b1, 1'b0, 2'b01, "carry_0100");
        pulse(0, 1'b1, 1'b0, 1'b0);
        wait_cyc(b + 10);

        // Back to IDLE on dut0: pause then clear.
        expect_at(b + 12, 0, 16'h0000, 1'b0, 1'b0, 2'b00, "clear_idle0");
        pulse(0, 1'b1, 1'b0, 1'b0);
        pulse(0, 1'b0, 1'b0, 1'b1);

        // Overflow on dut1 (tick every running cycle: count k visible at T+1+k).
        b = cyc;
        expect_at(b + 1,     1, 16'h0000, 1'b1, 1'b0, 2'b01, "ovf_start");
        expect_at(b + 2,     1, 16'h0001, 1'b1, 1'b0, 2'b01, "div1_tick");
        expect_at(b + 10000, 1, 16'h9999, 1'b1, 1'b0, 2'b01, "all_nines");
        expect_at(b + 10001, 1, 16'h0000, 1'b1, 1'b1, 2'b01, "wrap_ovf");
        pulse(1, 1'b1, 1'b0, 1'b0);
        wait_cyc(b + 10001);
        expect_at(b + 10002, 1, 16'h0001, 1'b1, 1'b1, 2'b01, "clear_in_run");
        pulse(1, 1'b0, 1'b0, 1'b1);
        // Stop coincides with a tick: the increment still lands.
        expect_at(b + 10003, 1, 16'h0002, 1'b0, 1'b1, 2'b10, "stop_on_tick");
        pulse(1, 1'b1, 1'b0, 1'b0);
        wait_cyc(b + 10005);
        expect_at(b + 10006, 1, 16'h0000, 1'b0, 1'b0, 2'b00, "clear_ovf");
        pulse(1, 1'b0, 1'b0, 1'b1);

        // Lap coinciding with a tick captures the pre-increment value.
        b = cyc;
        expect_at(b + 1, 1, 16'h0000, 1'b1, 1'b0, 2'b01, "lap_tick_start");
        expect_at(b + 4, 1, 16'h0003, 1'b1, 1'b0, 2'b01, "lap_tick_pre");
        pulse(1, 1'b1, 1'b0, 1'b0);
        wait_cyc(b + 4);
        expect_at(b + 5, 1, 16'h0003, 1'b1, 1'b0, 2'b11, "lap_capture_pre");
        expect_at(b + 6, 1, 16'h0003, 1'b1, 1'b0, 2'b11, "lap_frozen");
        pulse(1, 1'b0, 1'b1, 1'b0);
        wait_cyc(b + 6);
        expect_at(b + 7, 1, 16'h0006, 1'b0, 1'b0, 2'b10, "lap_to_pause_live");
        pulse(1, 1'b1, 1'b0, 1'b0);

        // Lap freeze on dut0 at 0042 while the live count moves on to 0050.
        b = cyc;
        expect_at(b + 1,   0, 16'h0000, 1'b1, 1'b0, 2'b01, "lap_run_start");
        expect_at(b + 421, 0, 16'h0042, 1'b1, 1'b0, 2'b01, "count_42");
        pulse(0, 1'b1, 1'b0, 1'b0);
        wait_cyc(b + 421);
        expect_at(b + 422, 0, 16'h0042, 1'b1, 1'b0, 2'b11, "lap_42");
        expect_at(b + 500, 0, 16'h0042, 1'b1, 1'b0, 2'b11, "lap_still_42");
        pulse(0, 1'b0, 1'b1, 1'b0);
        wait_cyc(b + 501);
        expect_at(b + 502, 0, 16'h0050, 1'b1, 1'b0, 2'b01, "lap_release_50");
        expect_at(b + 511, 0, 16'h0051, 1'b1, 1'b0, 2'b01, "rate_after_lap");
        pulse(0, 1'b0, 1'b1, 1'b0);
        wait_cyc(b + 512);
        expect_at(b + 513, 0, 16'h0051, 1'b0, 1'b0, 2'b10, "pause_51");
        pulse(0, 1'b1, 1'b0, 1'b0);
        wait_cyc(b + 520);
        expect_at(b + 521, 0, 16'h0000, 1'b0, 1'b0, 2'b00, "clear_plus_ss");
        pulse(0, 1'b1, 1'b0, 1'b1);
        wait_cyc(b + 530);
        expect_at(b + 531, 0, 16'h0000, 1'b0, 1'b0, 2'b00, "lap_in_idle");
        pulse(0, 1'b0, 1'b1, 1'b0);

        // Asynchronous reset mid-run at 0317.
        b = cyc;
        expect_at(b + 1,    0, 16'h0000, 1'b1, 1'b0, 2'b01, "r_start");
        expect_at(b + 3171, 0, 16'h0317, 1'b1, 1'b0, 2'b01, "count_317");
        expect_at(b + 3175, 0, 16'h0317, 1'b1, 1'b0, 2'b01, "count_317_hold");
        pulse(0, 1'b1, 1'b0, 1'b0);
        wait_cyc(b + 3175);
        @(posedge clk);
        #1;
        // No rising edge occurs between reset assertion and the next check.
        expect_at(cyc, 0, 16'h0000, 1'b0, 1'b0, 2'b00, "async_reset0");
        expect_at(cyc, 1, 16'h0000, 1'b0, 1'b0, 2'b00, "async_reset1");
        #1;
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        expect_at(cyc + 1, 0, 16'h0000, 1'b0, 1'b0, 2'b00, "post_reset_idle");
        wait_cyc(cyc + 2);
        b = cyc;
        expect_at(b + 1,  0, 16'h0000, 1'b1, 1'b0, 2'b01, "restart");
        expect_at(b + 10, 0, 16'h0000, 1'b1, 1'b0, 2'b01, "restart_pre");
        expect_at(b + 11, 0, 16'h0001, 1'b1, 1'b0, 2'b01, "restart_tick");
        pulse(0, 1'b1, 1'b0, 1'b0);
        wait_cyc(b + 12);

        for (int i = 0; i < 50 && sb.size() > 0; i++) @(negedge clk);
        if (sb.size() > 0) begin
            errors = errors + 1;
            $display("FAIL drain: %0d expectations never checked", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
